// File: rtl/seq_detect_multi.sv
`default_nettype none
// ============================================================================
// seq_detect_multi: multi-lane serial pattern detector with saturating hit
// counter. Optional step-key debouncer enabled by SEQDET_DEBOUNCE_EN.
// Revision: 1.0
// ============================================================================
module seq_detect_multi #(
  parameter int              PAT_W     = 8,
  parameter logic [PAT_W-1:0] PATTERN  = 8'b10100101,
  parameter int              LANES     = 4,
  parameter int              CNT_W     = 4,
  parameter int              DB_CYCLES = 400
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             step_key,
  input  logic             clear,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] din_echo,
  output logic [LANES-1:0] hits,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int SUM_W  = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic             sync1_q;
  logic             key_s_q;
  logic             key_db;
  logic             db_prev_q;
  logic             step_fire_q;

  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-2:0] hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [LANES-1:0] hits_q;
  logic [LANES-1:0] hit_d;
  logic [LANES-1:0] din_echo_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] sum_d;
  logic [PAT_W-1:0] win;
  logic             match_pulse_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= step_key;
      key_s_q <= sync1_q;
    end
  end

`ifdef SEQDET_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  // Counter value one short of DB_CYCLES-1: the increment would reach it this cycle
  localparam logic [DB_W-1:0] DB_LAST = DB_W'((DB_CYCLES > 1) ? DB_CYCLES - 2 : 0);

  logic            key_prev_q;
  logic            key_db_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q <= 1'b0;
      key_db_q   <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      key_prev_q <= key_s_q;
      if (key_s_q != key_prev_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        key_db_q <= key_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign key_db = key_db_q;
`else
  assign key_db = key_s_q;
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q   <= 1'b0;
      step_fire_q <= 1'b0;
    end else begin
      db_prev_q   <= key_db;
      step_fire_q <= key_db & ~db_prev_q;
    end
  end

  // All lanes are folded through the history in one cycle, oldest lane first
  always_comb begin
    hist_d = hist_q;
    hit_d  = '0;
    win    = '0;
    sum_d  = SUM_W'(match_cnt_q);
    for (int k = LANES - 1; k >= 0; k--) begin
      win      = {hist_d, din[k]};
      hit_d[k] = (win == PATTERN) && ((int'(fill_q) + LANES - k) >= PAT_W);
      hist_d   = win[PAT_W-2:0];
      sum_d    = sum_d + SUM_W'(hit_d[k]);
    end
    fill_d = ((int'(fill_q) + LANES) >= PAT_W) ? FILL_W'(PAT_W) : fill_q + FILL_W'(LANES);
    cnt_d  = (sum_d > CNT_MAX) ? {CNT_W{1'b1}} : sum_d[CNT_W-1:0];
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q        <= '0;
      fill_q        <= '0;
      hits_q        <= '0;
      din_echo_q    <= '0;
      match_cnt_q   <= '0;
      match_pulse_q <= 1'b0;
    end else if (clear) begin
      hist_q        <= '0;
      fill_q        <= '0;
      hits_q        <= '0;
      din_echo_q    <= '0;
      match_cnt_q   <= '0;
      match_pulse_q <= 1'b0;
    end else if (step_fire_q) begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      hits_q        <= hit_d;
      din_echo_q    <= din;
      match_cnt_q   <= cnt_d;
      match_pulse_q <= |hit_d;
    end else begin
      match_pulse_q <= 1'b0;
    end
  end

  assign din_echo    = din_echo_q;
  assign hits        = hits_q;
  assign match_pulse = match_pulse_q;
  assign match_cnt   = match_cnt_q;
  assign cnt_sat     = &match_cnt_q;

endmodule
`default_nettype wire
